// File: rtl/pong_match_ctrl.sv
// Match-flow sequencer for Pong: idle, 3-2-1 countdown, play, pause, game over; owns datapath reset and frame tick.
// Latency: every state and output change lands 1 clk after the frame_start that caused it; all outputs registered.
// Backpressure: none; frame_start pulses are consumed unconditionally, buttons are sampled once per frame.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int COUNT_FRAMES = 60,
  parameter int OVER_FRAMES  = 240
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [3:0] score_l,
  input  logic [3:0] score_r,
  output logic       game_rst,
  output logic       game_tick,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [1:0] winner,
  output logic       blink
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] COUNT_LAST = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [1:0] countdown_q, countdown_d;
  logic [1:0] winner_q, winner_d;
  logic       game_rst_q, game_rst_d;
  logic       game_tick_q, game_tick_d;
  logic       blink_q, blink_d;
  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       btn_start_q, btn_start_d;
  logic       btn_pause_q, btn_pause_d;

  logic       start_press;
  logic       pause_press;
  logic       rst_pulse;

  // Rising-edge detect against the previous frame's sample, so a held button counts once.
  assign start_press = frame_start & btn_start & ~btn_start_q;
  assign pause_press = frame_start & btn_pause & ~btn_pause_q;

  // Next-state and next-output logic; everything holds except on frame_start cycles.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    countdown_d = countdown_q;
    winner_d    = winner_q;
    game_tick_d = 1'b0;
    blink_cnt_d = blink_cnt_q;
    btn_start_d = btn_start_q;
    btn_pause_d = btn_pause_q;
    rst_pulse   = 1'b0;

    if (frame_start) begin
      btn_start_d = btn_start;
      btn_pause_d = btn_pause;
      blink_cnt_d = blink_cnt_q + 4'd1;

      unique case (state_q)
        S_IDLE: begin
          if (start_press) begin
            state_d     = S_COUNT;
            frame_cnt_d = 8'd0;
            countdown_d = 2'd3;
          end
        end
        S_COUNT: begin
          if (frame_cnt_q == COUNT_LAST) begin
            frame_cnt_d = 8'd0;
            if (countdown_q == 2'd1) begin
              state_d     = S_PLAY;
              countdown_d = 2'd0;
            end else begin
              countdown_d = countdown_q - 2'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        S_PLAY: begin
          // Win check precedes the tick; left wins a tie.
          if (score_l == WIN_VAL) begin
            state_d     = S_OVER;
            winner_d    = 2'b01;
            frame_cnt_d = 8'd0;
          end else if (score_r == WIN_VAL) begin
            state_d     = S_OVER;
            winner_d    = 2'b10;
            frame_cnt_d = 8'd0;
          end else if (pause_press) begin
            state_d     = S_PAUSE;
            frame_cnt_d = 8'd0;
          end else begin
            game_tick_d = 1'b1;
          end
        end
        S_PAUSE: begin
          if (pause_press) begin
            state_d     = S_PLAY;
            frame_cnt_d = 8'd0;
          end
        end
        S_OVER: begin
          // A restart beats the timeout when both land on the same frame.
          if (start_press) begin
            state_d     = S_COUNT;
            frame_cnt_d = 8'd0;
            countdown_d = 2'd3;
            winner_d    = 2'b00;
            rst_pulse   = 1'b1;
          end else if (frame_cnt_q == OVER_LAST) begin
            state_d     = S_IDLE;
            frame_cnt_d = 8'd0;
            winner_d    = 2'b00;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          frame_cnt_d = 8'd0;
          countdown_d = 2'd0;
          winner_d    = 2'b00;
        end
      endcase
    end

    // Datapath held in reset while idle; a one-clock pulse clears scores on a rematch.
    game_rst_d = (state_d == S_IDLE) | rst_pulse;

    if ((state_d == S_COUNT) || (state_d == S_PLAY)) begin
      blink_d = 1'b0;
    end else if (frame_start && (blink_cnt_q == 4'd15)) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= 8'd0;
      countdown_q <= 2'd0;
      winner_q    <= 2'b00;
      game_rst_q  <= 1'b1;
      game_tick_q <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= 4'd0;
      btn_start_q <= 1'b0;
      btn_pause_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      countdown_q <= countdown_d;
      winner_q    <= winner_d;
      game_rst_q  <= game_rst_d;
      game_tick_q <= game_tick_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      btn_start_q <= btn_start_d;
      btn_pause_q <= btn_pause_d;
    end
  end

  assign state     = state_q;
  assign countdown = countdown_q;
  assign winner    = winner_q;
  assign game_rst  = game_rst_q;
  assign game_tick = game_tick_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: walks a full match flow and checks every output against hand-derived values.
// Latency: frames are 4 clocks apart; outputs sampled on the negedge after the frame's posedge.
// Backpressure: not applicable; the bench drives frame_start and buttons directly.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [3:0] score_l = 4'd0;
  logic [3:0] score_r = 4'd0;
  logic       game_rst;
  logic       game_tick;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [1:0] winner;
  logic       blink;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  int rst_cnt  = 0;

  pong_match_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .score_l     (score_l),
    .score_r     (score_r),
    .game_rst    (game_rst),
    .game_tick   (game_tick),
    .state       (state),
    .countdown   (countdown),
    .winner      (winner),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  // Count clock cycles during which the pulsed outputs are high.
  always @(posedge clk) begin
    if (game_tick) tick_cnt <= tick_cnt + 1;
    if (game_rst)  rst_cnt  <= rst_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame: pulse on one posedge, sample on the following negedge, then two idle clocks.
  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    frame();
    btn_start = 1'b0;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    frame();
    btn_pause = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_game_rst", game_rst, 1);
    check("rst_tick", game_tick, 0);
    check("rst_countdown", countdown, 0);
    check("rst_winner", winner, 0);
    check("rst_blink", blink, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Blink toggles on the 16th frame in IDLE
    frames(15);
    check("blink_15", blink, 0);
    frame();
    check("blink_16", blink, 1);
    check("idle_state", state, 0);

    // Start held for 3 frames: single COUNTDOWN entry
    btn_start = 1'b1;
    frame();
    check("cd_enter_state", state, 1);
    check("cd_enter_digit", countdown, 3);
    check("cd_enter_rst", game_rst, 0);
    check("cd_blink", blink, 0);
    frames(2);
    btn_start = 1'b0;
    check("cd_held_digit", countdown, 3);
    btn_pause = 1'b1;
    frames(57);
    btn_pause = 1'b0;
    check("cd_3_last", countdown, 3);
    check("cd_pause_ignored", state, 1);
    frame();
    check("cd_2_first", countdown, 2);
    frames(59);
    check("cd_2_last", countdown, 2);
    frame();
    check("cd_1_first", countdown, 1);
    frames(59);
    check("cd_1_last", countdown, 1);
    tick_cnt = 0;
    frame();
    check("play_enter_state", state, 2);
    check("play_enter_digit", countdown, 0);
    check("play_enter_noTick", tick_cnt, 0);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("play_first_tick", game_tick, 1);
    @(negedge clk);
    check("play_tick_pulse", game_tick, 0);
    check("play_tick_count", tick_cnt, 1);

    // Pause and resume
    tick_cnt = 0;
    press_pause();
    check("pause_state", state, 3);
    frames(100);
    check("pause_still", state, 3);
    check("pause_no_ticks", tick_cnt, 0);
    press_pause();
    check("resume_state", state, 2);
    check("resume_noTick", tick_cnt, 0);
    frame();
    check("resume_tick", tick_cnt, 1);

    // Start press in PLAY ignored
    press_start();
    check("play_start_ignored", state, 2);

    // Right wins; OVER times out after 240 frames
    score_r = 4'd7;
    tick_cnt = 0;
    frame();
    check("over_r_state", state, 4);
    check("over_r_winner", winner, 2);
    check("over_r_noTick", tick_cnt, 0);
    check("over_r_rst", game_rst, 0);
    frames(239);
    check("over_hold_state", state, 4);
    check("over_hold_winner", winner, 2);
    frame();
    check("timeout_state", state, 0);
    check("timeout_rst", game_rst, 1);
    check("timeout_winner", winner, 0);
    score_r = 4'd0;

    // Back to PLAY, then a tie on the win score
    press_start();
    frames(180);
    check("replay_state", state, 2);
    score_l = 4'd7;
    score_r = 4'd7;
    repeat (10) @(negedge clk);
    check("no_frame_no_change", state, 2);
    frame();
    check("tie_state", state, 4);
    check("tie_winner", winner, 1);
    score_l = 4'd0;
    score_r = 4'd0;

    // Rematch start on the same frame as the timeout
    frames(239);
    check("pre_timeout_state", state, 4);
    rst_cnt = 0;
    press_start();
    check("rematch_state", state, 1);
    check("rematch_digit", countdown, 3);
    check("rematch_winner", winner, 0);
    check("rematch_rst_1clk", rst_cnt, 1);
    check("rematch_rst_low", game_rst, 0);

    // Asynchronous reset mid-PLAY, while a tick is high
    frames(180);
    check("play2_state", state, 2);
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #2;
    check("tick_before_rst", game_tick, 1);
    reset_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_rst", game_rst, 1);
    check("arst_tick", game_tick, 0);
    check("arst_winner", winner, 0);
    @(negedge clk);
    frame_start = 1'b0;
    btn_start = 1'b1;
    frame();
    check("frame_in_rst_ignored", state, 0);
    btn_start = 1'b0;
    reset_n = 1'b1;
    frame();
    check("post_rst_idle", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
